// File: rtl/checkout_pkg.sv
// Shared types and constants for the two-lane checkout controller.
package checkout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIFY,
    ALARM
  } state_e;

  localparam int unsigned U_BIT = 3;
  localparam int unsigned P_BIT = 2;
  localparam int unsigned C_BIT = 1;
  localparam int unsigned M_BIT = 0;

endpackage

// File: rtl/checkout_arbiter_item_classify.sv
// Combinational item classifier: maps a {U,P,C,M} code to discount / stolen flags.
module item_classify
  import checkout_pkg::*;
(
  input  logic [3:0] code,
  output logic       discount,
  output logic       stolen
);

  logic expensive;

  always_comb begin
    discount  = code[P_BIT] | (code[U_BIT] & code[C_BIT]);
    expensive = ~code[P_BIT] & (code[U_BIT] | code[C_BIT]);
    stolen    = expensive & ~code[M_BIT];
  end

endmodule

// File: rtl/checkout_arbiter.sv
// Two-lane round-robin checkout controller with saturating tallies and a sticky
// theft alarm that blocks scanning until the operator clears it.
module checkout_arbiter
  import checkout_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [3:0]       code0,
  input  logic [3:0]       code1,
  input  logic             clr,
  output logic [1:0]       ack,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] disc_cnt,
  output logic             alarm,
  output logic             alarm_lane
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       ack_q, ack_d;
  logic [3:0]       code_q, code_d;
  logic             lane_q, lane_d;
  logic [CNT_W-1:0] item_cnt_q, item_cnt_d;
  logic [CNT_W-1:0] disc_cnt_q, disc_cnt_d;
  logic             alarm_q, alarm_d;
  logic             alarm_lane_q, alarm_lane_d;

  logic grant_lane;
  logic discount;
  logic stolen;

  item_classify u_classify (
    .code     (code_q),
    .discount (discount),
    .stolen   (stolen)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      ack_q        <= '0;
      code_q       <= '0;
      lane_q       <= 1'b0;
      item_cnt_q   <= '0;
      disc_cnt_q   <= '0;
      alarm_q      <= 1'b0;
      alarm_lane_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      code_q       <= code_d;
      lane_q       <= lane_d;
      item_cnt_q   <= item_cnt_d;
      disc_cnt_q   <= disc_cnt_d;
      alarm_q      <= alarm_d;
      alarm_lane_q <= alarm_lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (|req) state_d = CLASSIFY;
      CLASSIFY: state_d = stolen ? ALARM : IDLE;
      ALARM:    if (clr) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Contention goes to the lane not served last; a lone requester always wins.
  assign grant_lane = (req == 2'b11) ? ~last_grant_q : req[1];

  always_comb begin
    ack_d        = '0;
    code_d       = code_q;
    lane_d       = lane_q;
    last_grant_d = last_grant_q;
    item_cnt_d   = item_cnt_q;
    disc_cnt_d   = disc_cnt_q;
    alarm_d      = alarm_q;
    alarm_lane_d = alarm_lane_q;

    if (state_q == IDLE && |req) begin
      ack_d        = grant_lane ? 2'b10 : 2'b01;
      code_d       = grant_lane ? code1 : code0;
      lane_d       = grant_lane;
      last_grant_d = grant_lane;
    end

    if (clr) begin
      item_cnt_d = '0;
      disc_cnt_d = '0;
      alarm_d    = 1'b0;
    end else if (state_q == CLASSIFY) begin
      if (item_cnt_q != '1) item_cnt_d = item_cnt_q + CNT_W'(1);
      if (discount && disc_cnt_q != '1) disc_cnt_d = disc_cnt_q + CNT_W'(1);
    end

    // Setting the alarm takes priority over a simultaneous clear.
    if (state_q == CLASSIFY && stolen) begin
      alarm_d      = 1'b1;
      alarm_lane_d = lane_q;
    end
  end

  assign ack        = ack_q;
  assign item_cnt   = item_cnt_q;
  assign disc_cnt   = disc_cnt_q;
  assign alarm      = alarm_q;
  assign alarm_lane = alarm_lane_q;

endmodule
